// File: rtl/issueque_int.sv
// Integer issue queue: collapsing storage, CDB wakeup/bypass, oldest-ready select.
// Define ISSUEQUE_INT_FLUSH_EN to make the flush input clear the queue; otherwise flush is ignored.
module issueque_int #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dispatch_valid,
  output logic        dispatch_ready,
  input  logic [5:0]  dispatch_opcode,
  input  logic [5:0]  dispatch_rdtag,
  input  logic [5:0]  dispatch_rstag,
  input  logic [5:0]  dispatch_rttag,
  input  logic        dispatch_rsvalid,
  input  logic        dispatch_rtvalid,
  input  logic [31:0] dispatch_rsdata,
  input  logic [31:0] dispatch_rtdata,
  input  logic        cdb_valid,
  input  logic [5:0]  cdb_tag,
  input  logic [31:0] cdb_data,
  input  logic        flush,
  output logic        issueint_ready,
  output logic [5:0]  issueint_opcode,
  output logic [31:0] issueint_rsdata,
  output logic [31:0] issueint_rtdata,
  output logic [5:0]  issueint_rdtag,
  input  logic        issueint_equeueint_done
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic        valid;
    logic [5:0]  opcode;
    logic [5:0]  rdtag;
    logic [5:0]  rstag;
    logic        rsvalid;
    logic [31:0] rsdata;
    logic [5:0]  rttag;
    logic        rtvalid;
    logic [31:0] rtdata;
  } entry_t;

  entry_t        entry_q [DEPTH];
  entry_t        entry_d [DEPTH];
  entry_t        wokenEntry [DEPTH];
  entry_t        shiftedEntry [DEPTH];
  entry_t        newEntry;
  entry_t        selEntry;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW-1:0] selIdx;
  logic [CW-1:0] writeIdx;
  logic          anyReady;
  logic          accept;
  logic          retire;

  assign dispatch_ready = (count_q < CW'(DEPTH));
  assign accept         = dispatch_valid & dispatch_ready;
  assign retire         = issueint_equeueint_done & anyReady;
  assign writeIdx       = count_q - CW'(retire);

  // Select looks only at registered state so done never loops back into the outputs.
  always_comb begin
    anyReady = 1'b0;
    selIdx   = '0;
    selEntry = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!anyReady && entry_q[i].valid && entry_q[i].rsvalid && entry_q[i].rtvalid) begin
        anyReady = 1'b1;
        selIdx   = CW'(i);
        selEntry = entry_q[i];
      end
    end
  end

  assign issueint_ready  = anyReady;
  assign issueint_opcode = selEntry.opcode;
  assign issueint_rsdata = selEntry.rsdata;
  assign issueint_rtdata = selEntry.rtdata;
  assign issueint_rdtag  = selEntry.rdtag;

  always_comb begin
    newEntry         = '0;
    newEntry.valid   = 1'b1;
    newEntry.opcode  = dispatch_opcode;
    newEntry.rdtag   = dispatch_rdtag;
    newEntry.rstag   = dispatch_rstag;
    newEntry.rsvalid = dispatch_rsvalid;
    newEntry.rsdata  = dispatch_rsdata;
    newEntry.rttag   = dispatch_rttag;
    newEntry.rtvalid = dispatch_rtvalid;
    newEntry.rtdata  = dispatch_rtdata;
    // A broadcast in the dispatch cycle would otherwise be missed by the new entry.
    if (cdb_valid && !dispatch_rsvalid && (dispatch_rstag == cdb_tag)) begin
      newEntry.rsvalid = 1'b1;
      newEntry.rsdata  = cdb_data;
    end
    if (cdb_valid && !dispatch_rtvalid && (dispatch_rttag == cdb_tag)) begin
      newEntry.rtvalid = 1'b1;
      newEntry.rtdata  = cdb_data;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wokenEntry[i] = entry_q[i];
      if (cdb_valid && entry_q[i].valid && !entry_q[i].rsvalid &&
          (entry_q[i].rstag == cdb_tag)) begin
        wokenEntry[i].rsvalid = 1'b1;
        wokenEntry[i].rsdata  = cdb_data;
      end
      if (cdb_valid && entry_q[i].valid && !entry_q[i].rtvalid &&
          (entry_q[i].rttag == cdb_tag)) begin
        wokenEntry[i].rtvalid = 1'b1;
        wokenEntry[i].rtdata  = cdb_data;
      end
    end
  end

  // Entries at and above the retired slot collapse down one place.
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      shiftedEntry[i] = (retire && (CW'(i) >= selIdx)) ? wokenEntry[i+1] : wokenEntry[i];
    end
    shiftedEntry[DEPTH-1] = retire ? '0 : wokenEntry[DEPTH-1];
  end

  always_comb begin
    count_d = count_q + CW'(accept) - CW'(retire);
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = shiftedEntry[i];
      if (accept && (writeIdx == CW'(i))) begin
        entry_d[i] = newEntry;
      end
    end
`ifdef ISSUEQUE_INT_FLUSH_EN
    if (flush) begin
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_d[i].valid = 1'b0;
      end
    end
`endif
  end

`ifdef ISSUEQUE_INT_FLUSH_EN
`else
  logic unused_flush;
  assign unused_flush = flush;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      entry_q <= entry_d;
    end
  end

endmodule

// File: tb/tb_issueque_int.sv
// Directed self-checking bench for issueque_int (DEPTH=4).
module tb_issueque_int;

  logic        clk = 1'b0;
  logic        reset;
  logic        dispatch_valid;
  logic        dispatch_ready;
  logic [5:0]  dispatch_opcode;
  logic [5:0]  dispatch_rdtag;
  logic [5:0]  dispatch_rstag;
  logic [5:0]  dispatch_rttag;
  logic        dispatch_rsvalid;
  logic        dispatch_rtvalid;
  logic [31:0] dispatch_rsdata;
  logic [31:0] dispatch_rtdata;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        flush;
  logic        issueint_ready;
  logic [5:0]  issueint_opcode;
  logic [31:0] issueint_rsdata;
  logic [31:0] issueint_rtdata;
  logic [5:0]  issueint_rdtag;
  logic        issueint_equeueint_done;

  int passCount  = 0;
  int failCount  = 0;
  int checkCount = 0;

  issueque_int #(.DEPTH(4)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .dispatch_valid          (dispatch_valid),
    .dispatch_ready          (dispatch_ready),
    .dispatch_opcode         (dispatch_opcode),
    .dispatch_rdtag          (dispatch_rdtag),
    .dispatch_rstag          (dispatch_rstag),
    .dispatch_rttag          (dispatch_rttag),
    .dispatch_rsvalid        (dispatch_rsvalid),
    .dispatch_rtvalid        (dispatch_rtvalid),
    .dispatch_rsdata         (dispatch_rsdata),
    .dispatch_rtdata         (dispatch_rtdata),
    .cdb_valid               (cdb_valid),
    .cdb_tag                 (cdb_tag),
    .cdb_data                (cdb_data),
    .flush                   (flush),
    .issueint_ready          (issueint_ready),
    .issueint_opcode         (issueint_opcode),
    .issueint_rsdata         (issueint_rsdata),
    .issueint_rtdata         (issueint_rtdata),
    .issueint_rdtag          (issueint_rdtag),
    .issueint_equeueint_done (issueint_equeueint_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] rd,
                               input logic [5:0] rsTag, input logic rsValid, input logic [31:0] rsData,
                               input logic [5:0] rtTag, input logic rtValid, input logic [31:0] rtData);
    dispatch_valid   = 1'b1;
    dispatch_opcode  = op;
    dispatch_rdtag   = rd;
    dispatch_rstag   = rsTag;
    dispatch_rsvalid = rsValid;
    dispatch_rsdata  = rsData;
    dispatch_rttag   = rtTag;
    dispatch_rtvalid = rtValid;
    dispatch_rtdata  = rtData;
  endtask

  task automatic cdbBroadcast(input logic [5:0] tag, input logic [31:0] data);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_data  = data;
  endtask

  // Only pulse done when an entry is offered; the bench treats anything else as an error.
  task automatic issueDone(input string tag);
    checkOutput({tag, "_ready_before_done"}, {31'd0, issueint_ready}, 32'd1);
    issueint_equeueint_done = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    dispatch_valid          = 1'b0;
    cdb_valid               = 1'b0;
    issueint_equeueint_done = 1'b0;
    flush                   = 1'b0;
  endtask

  task automatic checkIssue(input string tag, input logic expReady, input logic [5:0] expOp,
                            input logic [31:0] expRs, input logic [31:0] expRt, input logic [5:0] expRd);
    checkOutput({tag, "_ready"},  {31'd0, issueint_ready},  {31'd0, expReady});
    checkOutput({tag, "_opcode"}, {26'd0, issueint_opcode}, {26'd0, expOp});
    checkOutput({tag, "_rsdata"}, issueint_rsdata, expRs);
    checkOutput({tag, "_rtdata"}, issueint_rtdata, expRt);
    checkOutput({tag, "_rdtag"},  {26'd0, issueint_rdtag},  {26'd0, expRd});
  endtask

  task automatic checkDispReady(input string tag, input logic expected);
    checkOutput({tag, "_dispatch_ready"}, {31'd0, dispatch_ready}, {31'd0, expected});
  endtask

  initial begin
    reset                   = 1'b0;
    dispatch_valid          = 1'b0;
    dispatch_opcode         = '0;
    dispatch_rdtag          = '0;
    dispatch_rstag          = '0;
    dispatch_rttag          = '0;
    dispatch_rsvalid        = 1'b0;
    dispatch_rtvalid        = 1'b0;
    dispatch_rsdata         = '0;
    dispatch_rtdata         = '0;
    cdb_valid               = 1'b0;
    cdb_tag                 = '0;
    cdb_data                = '0;
    flush                   = 1'b0;
    issueint_equeueint_done = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkIssue("reset", 1'b0, 6'h00, 32'h0, 32'h0, 6'd0);
    checkDispReady("reset", 1'b1);
    reset = 1'b1;

    $display("[TB] basic dispatch and issue");
    applyStimulus(6'h20, 6'd3, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd7);
    tick();
    checkIssue("basic", 1'b1, 6'h20, 32'd5, 32'd7, 6'd3);
    issueDone("basic");
    tick();
    checkIssue("basic_after_done", 1'b0, 6'h00, 32'h0, 32'h0, 6'd0);

    $display("[TB] CDB wakeup");
    applyStimulus(6'h21, 6'd4, 6'd9, 1'b0, 32'h0, 6'd8, 1'b1, 32'd11);
    tick();
    checkIssue("wake_wait", 1'b0, 6'h00, 32'h0, 32'h0, 6'd0);
    cdbBroadcast(6'd9, 32'hDEAD_BEEF);
    tick();
    checkIssue("wake", 1'b1, 6'h21, 32'hDEAD_BEEF, 32'd11, 6'd4);
    issueDone("wake");
    tick();
    checkIssue("wake_after_done", 1'b0, 6'h00, 32'h0, 32'h0, 6'd0);

    $display("[TB] dispatch-time bypass");
    applyStimulus(6'h22, 6'd5, 6'd1, 1'b1, 32'h1, 6'd12, 1'b0, 32'h0);
    cdbBroadcast(6'd12, 32'h55);
    tick();
    checkIssue("bypass", 1'b1, 6'h22, 32'h1, 32'h55, 6'd5);
    issueDone("bypass");
    tick();
    checkIssue("bypass_after_done", 1'b0, 6'h00, 32'h0, 32'h0, 6'd0);

    $display("[TB] fill, out-of-order wake and compaction");
    applyStimulus(6'h01, 6'd10, 6'd20, 1'b0, 32'h0, 6'd30, 1'b1, 32'd100);
    tick();
    applyStimulus(6'h02, 6'd11, 6'd21, 1'b0, 32'h0, 6'd31, 1'b1, 32'd101);
    tick();
    applyStimulus(6'h03, 6'd12, 6'd22, 1'b0, 32'h0, 6'd32, 1'b1, 32'd102);
    tick();
    checkDispReady("fill3", 1'b1);
    applyStimulus(6'h04, 6'd13, 6'd23, 1'b0, 32'h0, 6'd33, 1'b1, 32'd103);
    tick();
    checkDispReady("full", 1'b0);
    checkIssue("full", 1'b0, 6'h00, 32'h0, 32'h0, 6'd0);
    applyStimulus(6'h3F, 6'd14, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2);
    tick();
    checkDispReady("full_drop", 1'b0);
    checkIssue("full_drop", 1'b0, 6'h00, 32'h0, 32'h0, 6'd0);
    cdbBroadcast(6'd22, 32'h222);
    tick();
    checkIssue("wake_e2", 1'b1, 6'h03, 32'h222, 32'd102, 6'd12);
    checkDispReady("wake_e2", 1'b0);
    issueDone("retire_e2");
    tick();
    checkDispReady("retire_e2", 1'b1);
    checkIssue("retire_e2", 1'b0, 6'h00, 32'h0, 32'h0, 6'd0);
    cdbBroadcast(6'd23, 32'h233);
    tick();
    checkIssue("wake_e3", 1'b1, 6'h04, 32'h233, 32'd103, 6'd13);
    cdbBroadcast(6'd21, 32'h211);
    tick();
    checkIssue("wake_e1", 1'b1, 6'h02, 32'h211, 32'd101, 6'd11);
    cdbBroadcast(6'd20, 32'h200);
    tick();
    checkIssue("wake_e0", 1'b1, 6'h01, 32'h200, 32'd100, 6'd10);
    issueDone("drain_e0");
    tick();
    checkIssue("drain_e0", 1'b1, 6'h02, 32'h211, 32'd101, 6'd11);
    issueDone("drain_e1");
    tick();
    checkIssue("drain_e1", 1'b1, 6'h04, 32'h233, 32'd103, 6'd13);
    issueDone("drain_e3");
    tick();
    checkIssue("drain_e3", 1'b0, 6'h00, 32'h0, 32'h0, 6'd0);
    checkDispReady("drain_e3", 1'b1);

    $display("[TB] simultaneous dispatch and retire");
    applyStimulus(6'h11, 6'd1, 6'd1, 1'b1, 32'hA1, 6'd2, 1'b1, 32'hA2);
    tick();
    applyStimulus(6'h12, 6'd2, 6'd1, 1'b1, 32'hB1, 6'd2, 1'b1, 32'hB2);
    tick();
    applyStimulus(6'h13, 6'd3, 6'd1, 1'b1, 32'hC1, 6'd2, 1'b1, 32'hC2);
    tick();
    checkIssue("sim_a", 1'b1, 6'h11, 32'hA1, 32'hA2, 6'd1);
    checkDispReady("sim_a", 1'b1);
    applyStimulus(6'h14, 6'd4, 6'd1, 1'b1, 32'hD1, 6'd2, 1'b1, 32'hD2);
    issueDone("sim_a");
    tick();
    checkIssue("sim_b", 1'b1, 6'h12, 32'hB1, 32'hB2, 6'd2);
    checkDispReady("sim_b", 1'b1);
    applyStimulus(6'h15, 6'd5, 6'd1, 1'b1, 32'hE1, 6'd2, 1'b1, 32'hE2);
    tick();
    checkDispReady("sim_full", 1'b0);
    checkIssue("sim_full", 1'b1, 6'h12, 32'hB1, 32'hB2, 6'd2);
    issueDone("b2b_b");
    tick();
    checkIssue("b2b_c", 1'b1, 6'h13, 32'hC1, 32'hC2, 6'd3);
    issueDone("b2b_c");
    tick();
    checkIssue("b2b_d", 1'b1, 6'h14, 32'hD1, 32'hD2, 6'd4);
    issueDone("b2b_d");
    tick();
    checkIssue("b2b_e", 1'b1, 6'h15, 32'hE1, 32'hE2, 6'd5);
    issueDone("b2b_e");
    tick();
    checkIssue("b2b_empty", 1'b0, 6'h00, 32'h0, 32'h0, 6'd0);
    checkDispReady("b2b_empty", 1'b1);

    $display("[TB] flush with simultaneous dispatch");
    applyStimulus(6'h31, 6'd6, 6'd1, 1'b1, 32'hF1, 6'd2, 1'b1, 32'hF2);
    tick();
    applyStimulus(6'h32, 6'd7, 6'd1, 1'b1, 32'hF3, 6'd2, 1'b1, 32'hF4);
    tick();
    applyStimulus(6'h33, 6'd8, 6'd1, 1'b1, 32'hF5, 6'd2, 1'b1, 32'hF6);
    tick();
    applyStimulus(6'h34, 6'd9, 6'd1, 1'b1, 32'hF7, 6'd2, 1'b1, 32'hF8);
    flush = 1'b1;
    tick();
`ifdef ISSUEQUE_INT_FLUSH_EN
    checkIssue("flush", 1'b0, 6'h00, 32'h0, 32'h0, 6'd0);
    checkDispReady("flush", 1'b1);
    tick();
    checkIssue("flush_dropped", 1'b0, 6'h00, 32'h0, 32'h0, 6'd0);
`else
    checkDispReady("flush_ignored", 1'b0);
    checkIssue("flush_ignored", 1'b1, 6'h31, 32'hF1, 32'hF2, 6'd6);
    issueDone("fl_1");
    tick();
    checkIssue("fl_2", 1'b1, 6'h32, 32'hF3, 32'hF4, 6'd7);
    issueDone("fl_2");
    tick();
    checkIssue("fl_3", 1'b1, 6'h33, 32'hF5, 32'hF6, 6'd8);
    issueDone("fl_3");
    tick();
    checkIssue("fl_4", 1'b1, 6'h34, 32'hF7, 32'hF8, 6'd9);
    issueDone("fl_4");
    tick();
    checkIssue("fl_empty", 1'b0, 6'h00, 32'h0, 32'h0, 6'd0);
`endif

    $display("[TB] asynchronous reset mid-operation");
    applyStimulus(6'h3A, 6'd15, 6'd1, 1'b1, 32'h77, 6'd2, 1'b1, 32'h88);
    tick();
    checkIssue("pre_reset", 1'b1, 6'h3A, 32'h77, 32'h88, 6'd15);
    #2;
    reset = 1'b0;
    #1;
    checkIssue("async_reset", 1'b0, 6'h00, 32'h0, 32'h0, 6'd0);
    checkDispReady("async_reset", 1'b1);
    @(negedge clk);
    reset = 1'b1;
    tick();
    checkIssue("post_reset", 1'b0, 6'h00, 32'h0, 32'h0, 6'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/issueque_int.md
# issueque_int

Integer issue queue: the consumer end of the issue/CDB protocol. Holds dispatched integer ops until both source operands are available, capturing missing operands by snooping CDB broadcasts (`cdb_valid`/`cdb_tag`/`cdb_data`). Presents the oldest ready op to the issue unit on the `issueint_*` bus and retires it when the issue unit returns `issueint_equeueint_done`. Sits between dispatch and the issue unit, in front of the integer exec unit.

## Interface
- `DEPTH`, 4: number of entries; legal values 2..16.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `dispatch_valid` in 1: dispatch presents a new op this cycle.
- `dispatch_ready` out 1: queue accepts the op; high iff `count < DEPTH`.
- `dispatch_opcode` in 6: ALU opcode.
- `dispatch_rdtag` in 6: destination tag.
- `dispatch_rstag`, `dispatch_rttag` in 6 each: source tags.
- `dispatch_rsvalid`, `dispatch_rtvalid` in 1 each: the operand's data is already valid.
- `dispatch_rsdata`, `dispatch_rtdata` in 32 each: operand data; meaningful only when the matching valid bit is high.
- `cdb_valid` in 1: CDB broadcast qualifier.
- `cdb_tag` in 6: CDB tag.
- `cdb_data` in 32: CDB data.
- `flush` in 1: discard all entries (see Configuration).
- `issueint_ready` out 1: at least one entry has both operands valid.
- `issueint_opcode` out 6: opcode of the selected entry.
- `issueint_rsdata`, `issueint_rtdata` out 32 each: operand data of the selected entry.
- `issueint_rdtag` out 6: destination tag of the selected entry.
- `issueint_equeueint_done` in 1: the issue unit took the selected entry this cycle.

## Operation
- Storage is a collapsing queue, oldest entry at index 0. Each entry holds: valid, opcode, rdtag, rstag, rsvalid, rsdata, rttag, rtvalid, rtdata.
- `count` register: width $clog2(DEPTH+1).
- **Dispatch accept.** The queue accepts when `dispatch_valid & dispatch_ready`. The new entry is written at the tail, index `count`, or `count-1` if an issue also retires this cycle.
- **Wakeup.** Every cycle `cdb_valid` is high, each valid entry with `rsvalid==0 && rstag==cdb_tag` sets `rsvalid` and captures `cdb_data` into `rsdata`. Same rule for rt. Both operands of one entry may wake on the same broadcast.
- **Dispatch-time bypass.** An accepted op whose source tag matches a valid CDB broadcast in the same cycle is written with that operand already valid and carrying `cdb_data`. This prevents a lost wakeup.
- **Select.** Ready entry = valid & rsvalid & rtvalid, evaluated from registered state only. A CDB wakeup makes an entry ready the following cycle.
  - The selected entry is the lowest-index ready entry.
  - `issueint_*` outputs are that entry's fields.
  - When no entry is ready, all `issueint_*` data outputs are 0 and `issueint_ready` is 0.
- **Retire.** On `issueint_equeueint_done` (which is valid only while `issueint_ready` is high), the selected entry is removed. Entries above it shift down one place, wakeup updates included. `count` decrements.
  - Done while not ready is ignored; the bench flags it as an error.
- **Simultaneous accept and retire.** `count` is unchanged. The new entry lands at `count-1` after the shift.
- `dispatch_ready` depends only on `count`. There is no accept-when-full-and-retiring.
- `issueint_ready` and the data outputs do not depend combinationally on `issueint_equeueint_done`. This breaks the loop with the issue unit's combinational done.

## Timing
- Reset (asynchronous, `reset` low):
  - all entry valid bits = 0, `count` = 0;
  - `dispatch_ready` = 1;
  - `issueint_ready` = 0, `issueint_opcode`/`issueint_rsdata`/`issueint_rtdata`/`issueint_rdtag` = 0.
  - Reset mid-operation drops all entries immediately.
- Dispatch with both operands valid: `issueint_ready` is high the next cycle (latency 1).
- Operand woken by CDB in cycle N: the entry is eligible in cycle N+1.
- Retire is registered: in the cycle after done, the outputs show the next-oldest ready entry.
- Back-to-back issue of one op per cycle is supported while ready entries exist.

## Configuration
- `ISSUEQUE_INT_FLUSH_EN` defined: `flush` high at a clock edge clears all valid bits and `count`.
  - Flush takes priority over dispatch and retire in the same cycle: both are dropped.
  - `dispatch_ready` is 1 in the next cycle.
- `ISSUEQUE_INT_FLUSH_EN` undefined: the `flush` port exists but is ignored, and no flush logic is synthesized.

## Test plan
- Reset, then dispatch op (opcode 6'h20, rs=5, rt=7 both valid, rdtag 3) -> next cycle `issueint_ready`=1, rsdata=5, rtdata=7, rdtag=3. Done pulse -> ready=0 the following cycle.
- Dispatch with rstag=9 invalid and rt valid; CDB broadcasts tag 9, data 32'hDEAD_BEEF in cycle N -> `issueint_ready`=0 in N, 1 in N+1 with rsdata=32'hDEAD_BEEF.
- Dispatch in the same cycle as a CDB broadcast of its rttag 12, data 32'h55 -> rtdata=32'h55, ready next cycle (bypass).
- Fill 4 entries, all not ready -> `dispatch_ready`=0. Wake entry 2 -> it issues first. On done, `dispatch_ready`=1 and entries 0,1,3 compact to 0,1,2 in order.
- Dispatch and done in the same cycle at count 3 -> count stays 3, and the new entry is the youngest.
- With `ISSUEQUE_INT_FLUSH_EN` defined: 3 entries plus a simultaneous dispatch, assert flush -> count 0, `issueint_ready` 0, and the dispatched op is dropped.
